// File: rtl/calc_program_loader.sv
// -----------------------------------------------------------------------------
// calc_program_loader
//
// Writer-side companion of the calculator fetch/decode path. Calculator
// operations (funct, immA, immB) arrive on a valid/ready stream. Each one is
// packed into a 32-bit instruction word and buffered in a small FIFO. The
// words are then written, one after another, into instruction memory. Write
// addresses are byte addresses that start at BASE_ADDR and step by 4, which
// matches the calculator's PC increment.
//
// Instruction word layout:
//   [31:29] funct   [28] zero   [27:14] immA   [13:0] immB
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all control state at once
//   start       one-cycle pulse that begins a program load (from IDLE or DONE)
//   in_valid    operation on in_* is valid
//   in_ready    loader accepts an operation this cycle (LOAD and FIFO not full)
//   in_last     final operation of the program, qualified by in_valid
//   in_funct    3-bit operation code
//   in_immA     14-bit immediate A
//   in_immB     14-bit immediate B
//   mem_stall   memory cannot take a write this cycle; holds off the FIFO pop
//   mem_wr_en   one-cycle write strobe per committed word
//   mem_addr    byte write address (holds its last value while idle)
//   mem_data    packed instruction (holds its last value while idle)
//   done        program fully written; stays high until the next start
//   word_count  words committed in the current program
//   overflow    sticky: the program exceeded DEPTH and words were dropped
//
// Parameters
//   BASE_ADDR   byte address of the first instruction
//   DEPTH       maximum instruction words per program
//   FIFO_DEPTH  input buffer entries; power of two, at least 2
// -----------------------------------------------------------------------------
module calc_program_loader #(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_funct,
  input  logic [13:0] in_immA,
  input  logic [13:0] in_immB,
  input  logic        mem_stall,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        done,
  output logic [10:0] word_count,
  output logic        overflow
);

  localparam int unsigned     PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]     BASE          = 32'(BASE_ADDR);
  localparam logic [10:0]     DEPTH_CNT     = 11'(DEPTH);
  localparam logic [31:0]     ADDR_STEP     = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Field packing; fields are copied verbatim with bit 28 forced to zero.
  function automatic logic [31:0] pack_instr(input logic [2:0]  funct,
                                             input logic [13:0] imm_a,
                                             input logic [13:0] imm_b);
    return {funct, 1'b0, imm_a, imm_b};
  endfunction

  // Saturation point of the program: no more words may be committed.
  function automatic logic at_capacity(input logic [10:0] count);
    return (count >= DEPTH_CNT);
  endfunction

  state_t state, state_nxt;

  // FSM-derived controls
  logic load_active;   // write side may pop (LOAD or DRAIN)
  logic start_load;    // accepted start pulse (IDLE or DONE)

  // FIFO
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop_p0;

  // Write pipeline
  logic [31:0] wr_addr_p0;   // address the next committed word will use
  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [31:0] data_p1;

  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start)                 state_nxt = S_LOAD;
      S_LOAD:  if (push && in_last)       state_nxt = S_DRAIN;
      // The final write must have left the output register before DONE.
      S_DRAIN: if (fifo_empty && !vld_p1) state_nxt = S_DONE;
      S_DONE:  if (start)                 state_nxt = S_LOAD;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // FSM: output logic; in_ready depends on registered state only
  always_comb begin
    in_ready    = 1'b0;
    done        = 1'b0;
    load_active = 1'b0;
    start_load  = 1'b0;
    unique case (state)
      S_IDLE: begin
        start_load = start;
      end
      S_LOAD: begin
        in_ready    = !fifo_full;
        load_active = 1'b1;
      end
      S_DRAIN: begin
        load_active = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        start_load = start;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign push   = in_valid && in_ready;
  assign pop_p0 = load_active && !fifo_empty && !mem_stall;

  // ---------------------------------------------------------------------------
  // Stage p0: FIFO push/pop. A push and a pop on the same edge leave the
  // occupancy unchanged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop_p0})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage is pure data; stale entries are never read because the pointers
  // and count are cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= pack_instr(in_funct, in_immA, in_immB);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered memory write port. A word popped at one edge is
  // driven during the following cycle. Once the program is full, popped words
  // are dropped: no strobe, address frozen, overflow latched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      addr_p1    <= BASE;
      data_p1    <= '0;
      wr_addr_p0 <= BASE;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (start_load) begin
        wr_addr_p0 <= BASE;
        word_count <= '0;
        overflow   <= 1'b0;
      end else if (pop_p0) begin
        if (at_capacity(word_count)) begin
          overflow <= 1'b1;
        end else begin
          vld_p1     <= 1'b1;
          addr_p1    <= wr_addr_p0;
          data_p1    <= fifo_mem[rd_ptr];
          wr_addr_p0 <= wr_addr_p0 + ADDR_STEP;
          word_count <= word_count + 11'd1;
        end
      end
    end
  end

  assign mem_wr_en = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_data  = data_p1;

endmodule
